// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, 8N1 frame constants and baud divider.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int   C_NBITS     = 8;
  localparam logic C_START_BIT = 1'b0;
  localparam logic C_STOP_BIT  = 1'b1;

  function automatic int f_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver on an already synchronised line; mid-bit sampling, glitch and framing rejection.
module uart_rx import uart_pkg::*; #(
  parameter int P_DIV = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Rx,
  output logic       o_fDone,
  output logic [7:0] o_Data
);
  localparam int CW = (P_DIV > 2) ? $clog2(P_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(P_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(P_DIV / 2 - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift, r_data, w_data;
  logic          r_prev, r_err, w_err, r_done, w_done;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_prev  <= 1'b1;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_prev  <= i_Rx;
      r_err   <= w_err;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_data  = r_data;
    w_err   = r_err;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        w_bit = '0;
        if (r_prev && !i_Rx) w_state = START;
      end
      START: if (r_cnt == C_HALF) begin
        w_cnt   = '0;
        w_state = (i_Rx == C_START_BIT) ? DATA : IDLE;
      end else w_cnt = r_cnt + CW'(1);
      DATA: if (r_cnt == C_LAST) begin
        w_cnt   = '0;
        w_shift = {i_Rx, r_shift[7:1]};
        if (r_bit == 3'(C_NBITS - 1)) w_state = STOP;
        else w_bit = r_bit + 3'd1;
      end else w_cnt = r_cnt + CW'(1);
      // A framing error parks here until the line returns high.
      STOP: if (r_err) begin
        if (i_Rx) begin
          w_err   = 1'b0;
          w_state = IDLE;
        end
      end else if (r_cnt == C_LAST) begin
        w_cnt = '0;
        if (i_Rx == C_STOP_BIT) begin
          w_data  = r_shift;
          w_done  = 1'b1;
          w_state = IDLE;
        end else w_err = 1'b1;
      end else w_cnt = r_cnt + CW'(1);
      default: w_state = IDLE;
    endcase
  end

  assign o_fDone = r_done;
  assign o_Data  = r_data;
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; line driven from a register, ready only while idle.
module uart_tx import uart_pkg::*; #(
  parameter int P_DIV = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_fTx,
  input  logic [7:0] i_Data,
  output logic       o_fDone,
  output logic       o_fReady,
  output logic       o_Tx
);
  localparam int CW = (P_DIV > 2) ? $clog2(P_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(P_DIV - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_data, w_data;
  logic          r_tx, w_tx, r_done, w_done;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_data  <= w_data;
      r_tx    <= w_tx;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_data  = r_data;
    w_tx    = r_tx;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (i_fTx) begin
        w_state = START;
        w_data  = i_Data;
        w_tx    = C_START_BIT;
        w_cnt   = '0;
        w_bit   = '0;
      end
      START: if (r_cnt == C_LAST) begin
        w_cnt   = '0;
        w_state = DATA;
        w_tx    = r_data[0];
      end else w_cnt = r_cnt + CW'(1);
      DATA: if (r_cnt == C_LAST) begin
        w_cnt = '0;
        if (r_bit == 3'(C_NBITS - 1)) begin
          w_state = STOP;
          w_tx    = C_STOP_BIT;
        end else begin
          w_bit = r_bit + 3'd1;
          w_tx  = r_data[w_bit];
        end
      end else w_cnt = r_cnt + CW'(1);
      STOP: if (r_cnt == C_LAST) begin
        w_cnt   = '0;
        w_state = IDLE;
        w_done  = 1'b1;
      end else w_cnt = r_cnt + CW'(1);
      default: w_state = IDLE;
    endcase
  end

  assign o_Tx     = r_tx;
  assign o_fDone  = r_done;
  assign o_fReady = (r_state == IDLE);
endmodule

// File: rtl/uart_top.sv
// UART with push-button-to-ASCII transmitter and byte receiver.
module uart_top import uart_pkg::*; #(
  parameter int P_CLK_HZ = 50_000_000,
  parameter int P_BAUD   = 115200
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Rx,
  output logic       o_Tx,
  input  logic [3:0] i_Push,
  output logic [7:0] o_RxData,
  output logic       o_fRxDone
);
  localparam int P_DIV = f_div(P_CLK_HZ, P_BAUD);

  logic       r_rx_s1, r_rx_s2;
  logic [3:0] r_push_s1, r_push_s2, r_push_d, r_pend;
  logic [3:0] w_press, w_clr;
  logic [7:0] w_tx_data;
  logic       w_fTx, w_tx_ready, w_tx_done;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_push_s1 <= 4'hF;
      r_push_s2 <= 4'hF;
      r_push_d  <= 4'hF;
      r_pend    <= 4'h0;
    end else begin
      r_rx_s1   <= i_Rx;
      r_rx_s2   <= r_rx_s1;
      r_push_s1 <= i_Push;
      r_push_s2 <= r_push_s1;
      r_push_d  <= r_push_s2;
      r_pend    <= (r_pend & ~w_clr) | w_press;
    end
  end

  assign w_press = r_push_d & ~r_push_s2;

  // Descending scan so the lowest pending button wins.
  always_comb begin
    w_clr     = 4'h0;
    w_tx_data = 8'h30;
    for (int i = 3; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_clr     = 4'(1 << i);
        w_tx_data = 8'h30 + 8'(i);
      end
    end
    w_fTx = (w_tx_ready | w_tx_done) && (r_pend != 4'h0);
    if (!w_fTx) w_clr = 4'h0;
  end

  uart_tx #(.P_DIV(P_DIV)) u_tx (
    .Clk(Clk), .Rst(Rst), .i_fTx(w_fTx), .i_Data(w_tx_data),
    .o_fDone(w_tx_done), .o_fReady(w_tx_ready), .o_Tx(o_Tx)
  );

  uart_rx #(.P_DIV(P_DIV)) u_rx (
    .Clk(Clk), .Rst(Rst), .i_Rx(r_rx_s2), .o_fDone(o_fRxDone), .o_Data(o_RxData)
  );
endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top at 50 MHz / 115200 baud.
`timescale 1ns/1ps
module tb_uart_top;
  localparam int P = 434;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       i_Rx = 1'b1;
  logic [3:0] i_Push = 4'hF;
  logic       o_Tx, o_fRxDone;
  logic [7:0] o_RxData;

  int errors = 0, checks = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0;

  uart_top dut (
    .Clk(Clk), .Rst(Rst), .i_Rx(i_Rx), .o_Tx(o_Tx),
    .i_Push(i_Push), .o_RxData(o_RxData), .o_fRxDone(o_fRxDone)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc++;
  always @(negedge Clk) if (o_fRxDone === 1'b1) begin done_cnt++; done_cyc = cyc; end

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, output int t0);
    @(negedge Clk);
    t0 = cyc;
    i_Rx = 1'b0;
    repeat (P) @(negedge Clk);
    for (int k = 0; k < 8; k++) begin
      i_Rx = b[k];
      repeat (P) @(negedge Clk);
    end
    i_Rx = stopb;
    repeat (P) @(negedge Clk);
  endtask

  // Reference receiver: every bit must hold its value for exactly P clocks.
  task automatic ref_rx(output logic [7:0] b, output int bad);
    logic [9:0] v;
    int n;
    n = 0; bad = 0; v = '0;
    @(negedge Clk);
    while (o_Tx !== 1'b0 && n < 300) begin @(negedge Clk); n++; end
    if (n >= 300) bad = 1000;
    else begin
      for (int i = 0; i < 10 * P; i++) begin
        if (i > 0) @(negedge Clk);
        if (i % P == 0) v[i / P] = o_Tx;
        else if (o_Tx !== v[i / P]) bad++;
      end
    end
    if (v[0] !== 1'b0 || v[9] !== 1'b1) bad++;
    b = v[8:1];
  endtask

  initial begin
    int t0, t1, bad, n, lows, base;
    logic [7:0] b;
    logic [3:0] pat;

    repeat (4) @(negedge Clk);
    check("rst_tx", 32'(o_Tx), 32'd1);
    check("rst_rxdata", 32'(o_RxData), 32'h00);
    check("rst_rxdone", 32'(o_fRxDone), 32'd0);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);

    // single RX frame; pulse lands at the stop-bit mid-sample (~9.5 bits)
    send_rx(8'h3C, 1'b1, t0);
    repeat (100) @(negedge Clk);
    check("rx1_count", 32'(done_cnt), 32'd1);
    check("rx1_data", 32'(o_RxData), 32'h3C);
    check("rx1_timing", 32'((done_cyc - t0) >= 4118 && (done_cyc - t0) <= 4134), 32'd1);

    send_rx(8'h3C, 1'b1, t0);
    send_rx(8'hE5, 1'b1, t1);
    repeat (100) @(negedge Clk);
    check("rx2_count", 32'(done_cnt), 32'd3);
    check("rx2_data", 32'(o_RxData), 32'hE5);

    // 100 ns low glitch
    base = done_cnt;
    i_Rx = 1'b0;
    repeat (5) @(negedge Clk);
    i_Rx = 1'b1;
    repeat (600) @(negedge Clk);
    check("rx_glitch", 32'(done_cnt - base), 32'd0);

    // stop bit 0, line held low a further bit, then released
    send_rx(8'h55, 1'b0, t0);
    repeat (P) @(negedge Clk);
    i_Rx = 1'b1;
    repeat (100) @(negedge Clk);
    check("rx_badstop_count", 32'(done_cnt - base), 32'd0);
    check("rx_badstop_data", 32'(o_RxData), 32'hE5);

    send_rx(8'hA7, 1'b1, t0);
    repeat (100) @(negedge Clk);
    check("rx_recover_count", 32'(done_cnt - base), 32'd1);
    check("rx_recover_data", 32'(o_RxData), 32'hA7);

    // one button at a time
    for (int k = 0; k < 4; k++) begin
      pat = 4'hF;
      pat[k] = 1'b0;
      i_Push = pat;
      ref_rx(b, bad);
      check($sformatf("tx_single%0d_data", k), 32'(b), 32'h30 + k);
      check($sformatf("tx_single%0d_frame", k), 32'(bad), 32'd0);
      repeat (700) @(negedge Clk);
    end
    i_Push = 4'hF;
    repeat (20) @(negedge Clk);

    // all four together, held
    i_Push = 4'h0;
    for (int k = 0; k < 4; k++) begin
      ref_rx(b, bad);
      check($sformatf("tx_multi%0d_data", k), 32'(b), 32'h30 + k);
      check($sformatf("tx_multi%0d_frame", k), 32'(bad), 32'd0);
    end
    lows = 0;
    repeat (2 * P) begin @(negedge Clk); if (o_Tx !== 1'b1) lows++; end
    check("tx_multi_noextra", 32'(lows), 32'd0);
    i_Push = 4'hF;
    repeat (20) @(negedge Clk);

    // reset mid-frame
    i_Push = 4'b1011;
    n = 0;
    while (o_Tx !== 1'b0 && n < 300) begin @(negedge Clk); n++; end
    check("tx_rst_started", 32'(n < 300), 32'd1);
    repeat (3 * P) @(negedge Clk);
    i_Push = 4'hF;
    Rst = 1'b1;
    @(negedge Clk);
    check("tx_rst_line", 32'(o_Tx), 32'd1);
    check("tx_rst_rxdata", 32'(o_RxData), 32'h00);
    Rst = 1'b0;
    lows = 0;
    repeat (2 * P) begin @(negedge Clk); if (o_Tx !== 1'b1) lows++; end
    check("tx_rst_abort", 32'(lows), 32'd0);

    i_Push = 4'b0111;
    ref_rx(b, bad);
    check("tx_after_rst_data", 32'(b), 32'h33);
    check("tx_after_rst_frame", 32'(bad), 32'd0);
    i_Push = 4'hF;
    repeat (20) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
